// File: rtl/mem_port_arbiter.sv
// Purpose : shares one memory port between instruction fetch (read-only) and load/store (read/write).
//           Round-robin on ties, one outstanding memory transaction, variable-latency memory with ack.
// Latency : req sampled in IDLE at N -> mem_en at N+1 -> mem_ack at M>=N+1 -> ack at M+1; misaligned -> ack+err at N+1.
// Backpressure: requesters hold req and their inputs stable until their ack; the stall is req && !ack.
//           A request arriving while a transaction is in flight waits until IDLE.
// Ports   : clk/rst (sync, active-low); if_req/if_addr -> if_ack/if_rdata; d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata;
//           err (qualifies either ack); mem_en/mem_we/mem_addr/mem_wdata -> memory, mem_ack/mem_rdata <- memory;
//           busy = not IDLE.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic          G_FETCH  = 1'b0;
    localparam logic          G_DATA   = 1'b1;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          last_grant, last_grant_n;
    logic          grant, grant_n;
    logic          is_store, is_store_n;

    logic          if_ack_n, d_ack_n, err_n, mem_en_n, mem_we_n;
    logic [DW-1:0] if_rdata_n, d_rdata_n, mem_wdata_n, resp_data;
    logic [AW-1:0] mem_addr_n, sel_addr;
    logic          pick;

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        last_grant_n = last_grant;
        grant_n      = grant;
        is_store_n   = is_store;
        if_ack_n     = 1'b0;
        d_ack_n      = 1'b0;
        err_n        = 1'b0;
        if_rdata_n   = '0;
        d_rdata_n    = '0;
        mem_en_n     = 1'b0;
        mem_we_n     = 1'b0;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        pick         = G_FETCH;
        sel_addr     = if_addr;
        resp_data    = '0;

        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    // Tie goes to whoever was not served last; a lone requester always wins.
                    if (if_req && d_req) pick = ~last_grant;
                    else                 pick = d_req ? G_DATA : G_FETCH;
                    sel_addr     = (pick == G_DATA) ? d_addr : if_addr;
                    grant_n      = pick;
                    last_grant_n = pick;
                    is_store_n   = (pick == G_DATA) && d_we;
                    if (sel_addr[1:0] != 2'b00) begin
                        // Misaligned: answer with an error straight away, memory untouched.
                        state_n  = RESP;
                        err_n    = 1'b1;
                        if_ack_n = (pick == G_FETCH);
                        d_ack_n  = (pick == G_DATA);
                    end else begin
                        state_n     = BUSY;
                        cnt_n       = '0;
                        mem_en_n    = 1'b1;
                        mem_we_n    = (pick == G_DATA) && d_we;
                        mem_addr_n  = sel_addr;
                        mem_wdata_n = (pick == G_DATA) ? d_wdata : '0;
                    end
                end
            end
            BUSY: begin
                cnt_n = cnt + CW'(1);
                // A memory ack on the final counted cycle still beats the timeout.
                if (mem_ack || (cnt == CNT_LAST)) begin
                    state_n   = RESP;
                    err_n     = !mem_ack;
                    resp_data = (mem_ack && !is_store) ? mem_rdata : '0;
                    if_ack_n  = (grant == G_FETCH);
                    d_ack_n   = (grant == G_DATA);
                    if (grant == G_DATA) d_rdata_n  = resp_data;
                    else                 if_rdata_n = resp_data;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= G_DATA;
            grant      <= G_FETCH;
            is_store   <= 1'b0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            err        <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            last_grant <= last_grant_n;
            grant      <= grant_n;
            is_store   <= is_store_n;
            if_ack     <= if_ack_n;
            d_ack      <= d_ack_n;
            err        <= err_n;
            if_rdata   <= if_rdata_n;
            d_rdata    <= d_rdata_n;
            mem_en     <= mem_en_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            busy       <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : directed self-checking bench for mem_port_arbiter with a simple variable-delay memory responder.
// Latency : checked in cycles from request raise to ack (counted on falling edges).
// Backpressure: requests held until ack, then dropped before the next IDLE sample.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          if_ack, d_ack, err, mem_en, mem_we, mem_ack, busy;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    // Memory input is the OR of the automatic responder and manual injection.
    logic          resp_ack = 1'b0, man_ack = 1'b0;
    logic [DW-1:0] resp_rdata = '0, man_rdata = '0;
    assign mem_ack   = resp_ack | man_ack;
    assign mem_rdata = resp_rdata | man_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder: acks mem_delay falling edges after seeing mem_en (-1 = never).
    int            mem_delay = 0;
    logic [DW-1:0] mem_val   = '0;
    int            en_cnt    = 0;
    logic          last_we   = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_wdata = '0;

    initial forever begin
        @(negedge clk);
        if (mem_en === 1'b1) en_cnt++;
    end

    initial forever begin
        @(negedge clk);
        if (mem_en === 1'b1) begin
            last_we    = mem_we;
            last_addr  = mem_addr;
            last_wdata = mem_wdata;
            if (mem_delay >= 0) begin
                repeat (mem_delay) @(negedge clk);
                resp_ack   = 1'b1;
                resp_rdata = mem_val;
                @(negedge clk);
                resp_ack   = 1'b0;
                resp_rdata = '0;
            end
        end
    end

    // One transaction: raise the request, wait (bounded) for its ack, drop it,
    // then confirm everything returns to zero on the following cycle.
    task automatic xact(input string tag, input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic e,
                        output int cyc);
        bit got = 0;
        logic other = 1'b0;
        rdata = '0;
        e     = 1'b0;
        cyc   = 0;
        if (is_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
        else      begin if_req = 1'b1; if_addr = addr; end
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (is_d ? d_ack : if_ack) begin
                got   = 1;
                rdata = is_d ? d_rdata : if_rdata;
                e     = err;
                other = is_d ? if_ack : d_ack;
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        check({tag, "_ack_seen"}, 32'(got), 32'd1);
        check({tag, "_other_ack"}, 32'(other), 32'd0);
        @(negedge clk);
        check({tag, "_idle_flags"}, {29'd0, if_ack, d_ack, err}, 32'd0);
        check({tag, "_idle_rdata"}, if_rdata | d_rdata, 32'd0);
    endtask

    logic [31:0] rd;
    logic        e;
    int          cyc, base;
    int          order[4];
    int          nack;
    bit          seen;
    logic        sticky;

    initial begin
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_if_ack", 32'(if_ack), 0);
        check("rst_d_ack", 32'(d_ack), 0);
        check("rst_err", 32'(err), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rdata", if_rdata | d_rdata, 0);
        rst = 1'b1;
        @(negedge clk);

        // Ties held continuously: F, D, F, D
        mem_delay = 0; mem_val = 32'hA5A5_0001;
        base = en_cnt;
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        nack = 0; cyc = 0;
        while (nack < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (if_ack || d_ack) begin
                order[nack] = d_ack ? 1 : 0;
                if (nack == 0) check("tie_first_rdata", if_rdata, 32'hA5A5_0001);
                nack++;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        check("tie_acks_seen", nack, 4);
        for (int i = 0; i < nack; i++) check($sformatf("tie_order%0d", i), order[i], i % 2);
        repeat (4) @(negedge clk);
        check("tie_mem_en_count", en_cnt - base, 4);

        // Fetch 0x10, memory acks two cycles after mem_en
        mem_delay = 2; mem_val = 32'hDEADBEEF;
        xact("fetch", 0, 0, 32'h10, 0, rd, e, cyc);
        check("fetch_rdata", rd, 32'hDEADBEEF);
        check("fetch_err", 32'(e), 0);
        check("fetch_latency", cyc, 4);
        check("fetch_mem_addr", last_addr, 32'h10);
        check("fetch_mem_we", 32'(last_we), 0);

        // Store: single strobe with we/addr/wdata, load data forced to zero
        mem_delay = 1; mem_val = 32'hFFFF_FFFF;
        base = en_cnt;
        xact("store", 1, 1, 32'h20, 32'h55, rd, e, cyc);
        check("store_rdata", rd, 0);
        check("store_err", 32'(e), 0);
        check("store_latency", cyc, 3);
        check("store_mem_we", 32'(last_we), 1);
        check("store_mem_addr", last_addr, 32'h20);
        check("store_mem_wdata", last_wdata, 32'h55);
        check("store_strobes", en_cnt - base, 1);

        // Load with same-cycle memory ack
        mem_delay = 0; mem_val = 32'h1234_5678;
        xact("load", 1, 0, 32'h24, 0, rd, e, cyc);
        check("load_rdata", rd, 32'h1234_5678);
        check("load_latency", cyc, 2);

        // Misaligned data address: immediate error, no strobe
        base = en_cnt;
        xact("misal", 1, 0, 32'h22, 0, rd, e, cyc);
        check("misal_err", 32'(e), 1);
        check("misal_rdata", rd, 0);
        check("misal_latency", cyc, 1);
        check("misal_strobes", en_cnt - base, 0);

        // Memory never acks: error after TIMEOUT busy cycles
        mem_delay = -1;
        xact("tmo", 0, 0, 32'h30, 0, rd, e, cyc);
        check("tmo_err", 32'(e), 1);
        check("tmo_rdata", rd, 0);
        check("tmo_latency", cyc, TO + 1);

        // Next request is serviced normally
        mem_delay = 1; mem_val = 32'hCAFE_F00D;
        xact("post_tmo", 0, 0, 32'h34, 0, rd, e, cyc);
        check("post_tmo_rdata", rd, 32'hCAFE_F00D);
        check("post_tmo_err", 32'(e), 0);

        // Reset in BUSY, then a stray memory ack
        mem_delay = -1;
        if_req = 1'b1; if_addr = 32'h40;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (mem_en) seen = 1;
        end
        check("rstb_mem_en_seen", 32'(seen), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstb_busy", 32'(busy), 0);
        check("rstb_mem_addr", mem_addr, 0);
        rst = 1'b1; if_req = 1'b0;
        man_ack = 1'b1; man_rdata = 32'h77;
        @(negedge clk);
        man_ack = 1'b0; man_rdata = '0;
        base = en_cnt;
        sticky = 1'b0;
        repeat (4) begin
            @(negedge clk);
            sticky = sticky | if_ack | d_ack | err | mem_en | busy | (|if_rdata) | (|d_rdata);
        end
        check("rstb_quiet", 32'(sticky), 0);
        check("rstb_no_strobe", en_cnt - base, 0);

        mem_delay = 0; mem_val = 32'h0BAD_CAFE;
        xact("rstb_next", 1, 0, 32'h48, 0, rd, e, cyc);
        check("rstb_next_rdata", rd, 32'h0BAD_CAFE);
        check("rstb_next_latency", cyc, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
